// File: rtl/hilo_unit.sv
// HI/LO architectural register pair with a 2-entry in-order write-staging FIFO.
// Captures divider, multiplier and move-to results, retires them on commit, and forwards the youngest staged value.
module hilo_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        div_ready,
  input  logic [31:0] div_q,
  input  logic [31:0] div_r,
  input  logic        mul_ready,
  input  logic [31:0] mul_hi,
  input  logic [31:0] mul_lo,
  input  logic        mthi_en,
  input  logic        mtlo_en,
  input  logic [31:0] mt_data,
  input  logic        commit,
  input  logic        flush,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out,
  output logic [1:0]  pend_cnt,
  output logic        full,
  output logic        ovf_err
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  typedef struct packed {
    logic        we_hi;
    logic        we_lo;
    logic [31:0] hi_val;
    logic [31:0] lo_val;
  } entry_t;

  state_t      r_state, w_state_nxt;
  entry_t      r_ent0, r_ent1;          // r_ent0 is the oldest (head) entry
  entry_t      w_ent0_nxt, w_ent1_nxt, w_new;
  logic [31:0] r_hi, r_lo;
  logic        r_ovf;
  logic        w_mt, w_cap, w_collide, w_pop, w_push, w_drop;

  assign w_mt      = mthi_en | mtlo_en;
  assign w_cap     = div_ready | mul_ready | w_mt;
  assign w_collide = (div_ready & mul_ready) | (div_ready & w_mt) | (mul_ready & w_mt);
  assign w_pop     = commit & (r_state != EMPTY) & ~flush;
  assign w_push    = w_cap & ~flush & ((r_state != TWO) | commit);
  assign w_drop    = w_cap & ~flush & (r_state == TWO) & ~commit;

  // Priority select of the single winning source: div > mul > move-to.
  always_comb begin
    w_new = '0;
    if (div_ready) begin
      w_new = '{we_hi: 1'b1, we_lo: 1'b1, hi_val: div_r, lo_val: div_q};
    end else if (mul_ready) begin
      w_new = '{we_hi: 1'b1, we_lo: 1'b1, hi_val: mul_hi, lo_val: mul_lo};
    end else begin
      w_new = '{we_hi: mthi_en, we_lo: mtlo_en, hi_val: mt_data, lo_val: mt_data};
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ent0_nxt  = r_ent0;
    w_ent1_nxt  = r_ent1;
    if (flush) begin
      w_state_nxt = EMPTY;
    end else begin
      unique case (r_state)
        EMPTY: begin
          if (w_push) begin
            w_ent0_nxt  = w_new;
            w_state_nxt = ONE;
          end
        end
        ONE: begin
          if (w_pop && w_push) begin
            w_ent0_nxt = w_new;
          end else if (w_pop) begin
            w_state_nxt = EMPTY;
          end else if (w_push) begin
            w_ent1_nxt  = w_new;
            w_state_nxt = TWO;
          end
        end
        TWO: begin
          if (w_pop) begin
            w_ent0_nxt = r_ent1;
            if (w_push) w_ent1_nxt = w_new;
            else        w_state_nxt = ONE;
          end
        end
        default: w_state_nxt = EMPTY;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) r_state <= EMPTY;
    else     r_state <= w_state_nxt;
  end

  // NOTE: entry payloads are not reset; r_state alone decides which entries are meaningful.
  always_ff @(posedge clk) begin
    r_ent0 <= w_ent0_nxt;
    r_ent1 <= w_ent1_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hi  <= '0;
      r_lo  <= '0;
      r_ovf <= 1'b0;
    end else begin
      if (w_pop && r_ent0.we_hi) r_hi <= r_ent0.hi_val;
      if (w_pop && r_ent0.we_lo) r_lo <= r_ent0.lo_val;
      if (w_drop || (w_collide && !flush)) r_ovf <= 1'b1;
    end
  end

  // Forward the youngest staged write per half, from registered state only.
  always_comb begin
    hi_out = r_hi;
    lo_out = r_lo;
    if (r_state != EMPTY) begin
      if (r_ent0.we_hi) hi_out = r_ent0.hi_val;
      if (r_ent0.we_lo) lo_out = r_ent0.lo_val;
    end
    if (r_state == TWO) begin
      if (r_ent1.we_hi) hi_out = r_ent1.hi_val;
      if (r_ent1.we_lo) lo_out = r_ent1.lo_val;
    end
  end

  assign pend_cnt = r_state;
  assign full     = (r_state == TWO);
  assign ovf_err  = r_ovf;

endmodule

// File: tb/tb_hilo_unit.sv
// Scoreboard bench for hilo_unit: the driver queues the expected outputs for each edge,
// and a negedge monitor pops and compares them when that edge has occurred.
module tb_hilo_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        div_ready, mul_ready, mthi_en, mtlo_en, commit, flush;
  logic [31:0] div_q, div_r, mul_hi, mul_lo, mt_data;
  logic [31:0] hi_out, lo_out;
  logic [1:0]  pend_cnt;
  logic        full, ovf_err;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct {
    int          due;
    string       name;
    logic [1:0]  pend;
    logic        full;
    logic        ovf;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  hilo_unit dut (
    .clk(clk), .rst(rst),
    .div_ready(div_ready), .div_q(div_q), .div_r(div_r),
    .mul_ready(mul_ready), .mul_hi(mul_hi), .mul_lo(mul_lo),
    .mthi_en(mthi_en), .mtlo_en(mtlo_en), .mt_data(mt_data),
    .commit(commit), .flush(flush),
    .hi_out(hi_out), .lo_out(lo_out),
    .pend_cnt(pend_cnt), .full(full), .ovf_err(ovf_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input exp_t e);
    n_tests++;
    if (pend_cnt !== e.pend || full !== e.full || ovf_err !== e.ovf ||
        hi_out !== e.hi || lo_out !== e.lo) begin
      n_fail++;
      $display("FAIL %s: got pend=%0d full=%0d ovf=%0d hi=%h lo=%h, want pend=%0d full=%0d ovf=%0d hi=%h lo=%h",
               name, pend_cnt, full, ovf_err, hi_out, lo_out, e.pend, e.full, e.ovf, e.hi, e.lo);
    end
  endtask

  // Monitor: compare every expectation at the negedge following its target edge.
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
      mon_e = exp_q.pop_front();
      n_tests++;
      n_fail++;
      $display("FAIL %s: expectation for cycle %0d never compared (now %0d)", mon_e.name, mon_e.due, cyc);
    end
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      mon_e = exp_q.pop_front();
      check(mon_e.name, mon_e);
    end
  end

  task automatic clear_inputs();
    rst = 1'b0; div_ready = 1'b0; mul_ready = 1'b0; mthi_en = 1'b0; mtlo_en = 1'b0;
    commit = 1'b0; flush = 1'b0;
    div_q = '0; div_r = '0; mul_hi = '0; mul_lo = '0; mt_data = '0;
  endtask

  // Apply the currently driven inputs for one edge and queue the outputs expected after it.
  task automatic step(input string name, input logic [1:0] pend, input logic fl, input logic ovf,
                      input logic [31:0] hi, input logic [31:0] lo);
    exp_t e;
    e.due = cyc + 1; e.name = name;
    e.pend = pend; e.full = fl; e.ovf = ovf; e.hi = hi; e.lo = lo;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    clear_inputs();
  endtask

  initial begin
    clear_inputs();

    // Reset overrides simultaneous capture and commit.
    rst = 1; div_ready = 1; div_q = 32'h7; div_r = 32'h2; commit = 1;
    step("reset", 0, 0, 0, 32'h0, 32'h0);

    div_ready = 1; div_q = 32'h7; div_r = 32'h2;
    step("div_capture", 1, 0, 0, 32'h2, 32'h7);
    commit = 1;
    step("div_commit", 0, 0, 0, 32'h2, 32'h7);
    commit = 1;
    step("commit_empty", 0, 0, 0, 32'h2, 32'h7);

    mthi_en = 1; mt_data = 32'hAAAA0000;
    step("mthi_capture", 1, 0, 0, 32'hAAAA0000, 32'h7);
    mul_ready = 1; mul_hi = 32'h1; mul_lo = 32'h2;
    step("mul_full", 2, 1, 0, 32'h1, 32'h2);
    mtlo_en = 1; mt_data = 32'h1234;
    step("drop_when_full", 2, 1, 1, 32'h1, 32'h2);
    commit = 1; flush = 1;
    step("flush_over_commit", 0, 0, 1, 32'h2, 32'h7);

    mtlo_en = 1; mt_data = 32'h5;
    step("mtlo_capture", 1, 0, 1, 32'h2, 32'h5);
    commit = 1; div_ready = 1; div_q = 32'h9; div_r = 32'h1;
    step("commit_and_push_one", 1, 0, 1, 32'h1, 32'h9);
    commit = 1;
    step("commit_div2", 0, 0, 1, 32'h1, 32'h9);

    mthi_en = 1; mt_data = 32'h11;
    step("mthi_partial", 1, 0, 1, 32'h11, 32'h9);
    mtlo_en = 1; mt_data = 32'h22;
    step("mixed_forward", 2, 1, 1, 32'h11, 32'h22);
    commit = 1; mul_ready = 1; mul_hi = 32'h33; mul_lo = 32'h44;
    step("commit_and_push_two", 2, 1, 1, 32'h33, 32'h44);
    commit = 1;
    step("commit_mtlo", 1, 0, 1, 32'h33, 32'h44);
    commit = 1;
    step("commit_mul", 0, 0, 1, 32'h33, 32'h44);
    flush = 1; div_ready = 1; div_q = 32'h55; div_r = 32'h66;
    step("flush_over_capture", 0, 0, 1, 32'h33, 32'h44);

    rst = 1;
    step("reset_clears_ovf", 0, 0, 0, 32'h0, 32'h0);
    div_ready = 1; div_q = 32'hA; div_r = 32'hB; mthi_en = 1; mt_data = 32'hFF;
    step("div_vs_mt_collision", 1, 0, 1, 32'hB, 32'hA);
    mul_ready = 1; mul_hi = 32'hC; mul_lo = 32'hD; mthi_en = 1; mt_data = 32'hEE;
    step("mul_vs_mt_collision", 2, 1, 1, 32'hC, 32'hD);
    rst = 1; commit = 1; flush = 1;
    step("reset_when_full", 0, 0, 0, 32'h0, 32'h0);

    mthi_en = 1; mtlo_en = 1; mt_data = 32'h8000BEEF;
    step("mt_both_halves", 1, 0, 0, 32'h8000BEEF, 32'h8000BEEF);
    commit = 1;
    step("commit_mt_both", 0, 0, 0, 32'h8000BEEF, 32'h8000BEEF);

    repeat (2) @(posedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
